// File: rtl/cl_int_pkg.sv
// Shared types and register map for the CL->shell interrupt controller.
package cl_int_pkg;

    typedef enum logic [1:0] {
        INT_IDLE = 2'd0,
        INT_FIRE = 2'd1,
        INT_WAIT = 2'd2
    } int_state_e;

    localparam logic [7:0] INT_CTRL_A      = 8'h00;
    localparam logic [7:0] INT_MASK_A      = 8'h04;
    localparam logic [7:0] INT_MODE_A      = 8'h08;
    localparam logic [7:0] INT_PEND_A      = 8'h0C;
    localparam logic [7:0] INT_DROP_BASE_A = 8'h40;

    localparam int INT_MAX_CH = 16;

endpackage

// File: rtl/cl_int_chan.sv
// One interrupt channel: event detect, IDLE/FIRE/WAIT tracking, pend/done flags and drop counter.
module cl_int_chan
    import cl_int_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             src_i,
    input  logic             mode_i,
    input  logic             mask_i,
    input  logic             sw_trig_i,
    input  logic             ack_i,
    input  logic             done_clr_i,
    input  logic             cnt_clr_i,
    output logic             trig_o,
    output logic             busy_o,
    output logic             pend_o,
    output logic             done_o,
    output logic [CNT_W-1:0] drop_cnt_o
);

    int_state_e       state_q;
    logic             src_q;
    logic             pend_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ev;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Level mode only counts as an event while idle, so a held level never double-books.
    assign ev    = sw_trig_i | (mode_i ? (src_i & (state_q == INT_IDLE)) : (src_i & ~src_q));
    assign cnt_d = cnt_clr_i ? CNT_W'(1) : sat_inc(cnt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INT_IDLE;
            src_q   <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            src_q <= src_i;
            if (done_clr_i) done_q <= 1'b0;
            if (cnt_clr_i)  cnt_q  <= '0;
            case (state_q)
                INT_IDLE: begin
                    if ((ev || pend_q) && !mask_i) begin
                        state_q <= INT_FIRE;
                        pend_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (ev) begin
                        pend_q <= 1'b1;
                    end
                end
                INT_FIRE: begin
                    state_q <= INT_WAIT;
                    if (ev) begin
                        if (pend_q) cnt_q  <= cnt_d;
                        else        pend_q <= 1'b1;
                    end
                end
                INT_WAIT: begin
                    if (ack_i) begin
                        done_q <= 1'b1;
                        // With both a pending event and a fresh one, the fresh one stays pending.
                        if ((pend_q || ev) && !mask_i) begin
                            state_q <= INT_FIRE;
                            pend_q  <= pend_q & ev;
                        end else begin
                            state_q <= INT_IDLE;
                            pend_q  <= pend_q | ev;
                        end
                    end else if (ev) begin
                        if (pend_q) cnt_q  <= cnt_d;
                        else        pend_q <= 1'b1;
                    end
                end
                default: state_q <= INT_IDLE;
            endcase
        end
    end

    assign trig_o     = (state_q == INT_FIRE);
    assign busy_o     = (state_q != INT_IDLE);
    assign pend_o     = pend_q;
    assign done_o     = done_q;
    assign drop_cnt_o = cnt_q;

endmodule

// File: rtl/lib_pipe.sv
// Plain register pipeline, STAGES deep, cleared by reset.
module lib_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/cl_int_ctrl_multi.sv
// Multi-channel CL->shell interrupt controller: cfg register port, per-channel FSMs, req/ack pipes.
module cl_int_ctrl_multi
    import cl_int_pkg::*;
#(
    parameter int NUM_CH      = 16,
    parameter int PIPE_STAGES = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] int_src,
    input  logic [7:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    input  logic              cfg_wr,
    input  logic              cfg_rd,
    output logic              cfg_ack,
    output logic [31:0]       cfg_rdata,
    output logic [15:0]       cl_sh_irq_req,
    input  logic [15:0]       sh_cl_irq_ack
);

    localparam logic [15:0] CH_VALID = 16'((17'h1 << NUM_CH) - 17'h1);

    logic [15:0]      src_w;
    logic [15:0]      mask_q, mode_q;
    logic [15:0]      trig, busy, pend, done, ack_p;
    logic [15:0]      sw_trig, done_clr, cnt_clr;
    logic [CNT_W-1:0] drop_cnt [INT_MAX_CH];
    logic             cfg_ack_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             ctrl_wr, drop_sel;
    logic [3:0]       drop_ch;

    assign src_w    = 16'(int_src);
    assign drop_sel = (cfg_addr[7:6] == INT_DROP_BASE_A[7:6]) && (cfg_addr[1:0] == 2'b00);
    assign drop_ch  = cfg_addr[5:2];
    assign ctrl_wr  = cfg_wr && (cfg_addr == INT_CTRL_A);
    assign sw_trig  = ctrl_wr ? (cfg_wdata[15:0]  & CH_VALID) : 16'h0;
    assign done_clr = ctrl_wr ? (cfg_wdata[31:16] & CH_VALID) : 16'h0;
    assign cnt_clr  = (cfg_wr && drop_sel) ? (CH_VALID & (16'h1 << drop_ch)) : 16'h0;

    for (genvar g = 0; g < INT_MAX_CH; g++) begin : g_ch
        if (g < NUM_CH) begin : g_on
            cl_int_chan #(.CNT_W(CNT_W)) u_chan (
                .clk        (clk),
                .rst_n      (rst_n),
                .src_i      (src_w[g]),
                .mode_i     (mode_q[g]),
                .mask_i     (mask_q[g]),
                .sw_trig_i  (sw_trig[g]),
                .ack_i      (ack_p[g]),
                .done_clr_i (done_clr[g]),
                .cnt_clr_i  (cnt_clr[g]),
                .trig_o     (trig[g]),
                .busy_o     (busy[g]),
                .pend_o     (pend[g]),
                .done_o     (done[g]),
                .drop_cnt_o (drop_cnt[g])
            );
        end else begin : g_off
            assign trig[g]     = 1'b0;
            assign busy[g]     = 1'b0;
            assign pend[g]     = 1'b0;
            assign done[g]     = 1'b0;
            assign drop_cnt[g] = '0;
        end
    end

    // Readback samples state before any same-cycle write lands.
    always_comb begin
        rdata_d = '0;
        if (cfg_rd) begin
            case (cfg_addr)
                INT_CTRL_A: rdata_d = {done, busy};
                INT_MASK_A: rdata_d = {16'h0, mask_q};
                INT_MODE_A: rdata_d = {16'h0, mode_q};
                INT_PEND_A: rdata_d = {16'h0, pend};
                default:    if (drop_sel) rdata_d = 32'(drop_cnt[drop_ch]);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q    <= '0;
            mode_q    <= '0;
            cfg_ack_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            cfg_ack_q <= cfg_wr | cfg_rd;
            rdata_q   <= rdata_d;
            if (cfg_wr && cfg_addr == INT_MASK_A) mask_q <= cfg_wdata[15:0] & CH_VALID;
            if (cfg_wr && cfg_addr == INT_MODE_A) mode_q <= cfg_wdata[15:0] & CH_VALID;
        end
    end

    assign cfg_ack   = cfg_ack_q;
    assign cfg_rdata = rdata_q;

    lib_pipe #(.WIDTH(16), .STAGES(PIPE_STAGES)) u_req_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (trig),
        .q_o   (cl_sh_irq_req)
    );

    lib_pipe #(.WIDTH(16), .STAGES(PIPE_STAGES)) u_ack_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (sh_cl_irq_ack),
        .q_o   (ack_p)
    );

endmodule
